// File: rtl/realtank_soc_busmtx_out_arb.sv
// Output-stage arbiter for the RealTank bus matrix: shares MI0 between up to four input stages.
// Define REALTANK_BUSMTX_ARB_RR_EN for round-robin selection; otherwise fixed priority (S0 highest).
module realtank_soc_busmtx_out_arb #(
  parameter int NUM_IN = 4
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [NUM_IN-1:0]   req_in,
  input  logic [2*NUM_IN-1:0] trans_in,
  input  logic [NUM_IN-1:0]   lock_in,
  input  logic                HREADYM,
  output logic [1:0]          addr_in_port,
  output logic                no_port,
  output logic [NUM_IN-1:0]   active_arb,
  output logic [1:0]          data_in_port,
  output logic                data_valid,
  output logic                locked
);

  typedef enum logic [1:0] {
    NOPORT = 2'd0,
    OWNED  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam logic [1:0] TRANS_BUSY = 2'b01;
  localparam logic [1:0] TRANS_SEQ  = 2'b11;

  arb_state_t state, state_n;
  logic [1:0] addr_n;
  logic       no_port_n;

  logic [3:0] req_pad;
  logic [3:0] lock_pad;
  logic [7:0] trans_pad;
  logic       owner_req;
  logic       owner_lock;
  logic [1:0] owner_trans;
  logic       owner_burst;

  logic       pick_found;
  logic [1:0] pick_idx;

`ifdef REALTANK_BUSMTX_ARB_RR_EN
  localparam logic [1:0] LAST_IDX = 2'(NUM_IN - 1);
  logic [1:0] rr_ptr;
  logic [1:0] cand;
  logic       grant_new;
`endif

  // Pad to four inputs so owner lookups never index past NUM_IN.
  always_comb begin
    req_pad   = '0;
    lock_pad  = '0;
    trans_pad = '0;
    req_pad[NUM_IN-1:0]     = req_in;
    lock_pad[NUM_IN-1:0]    = lock_in;
    trans_pad[2*NUM_IN-1:0] = trans_in;
  end

  assign owner_req   = req_pad[addr_in_port];
  assign owner_lock  = lock_pad[addr_in_port];
  assign owner_trans = trans_pad[{addr_in_port, 1'b0} +: 2];
  assign owner_burst = owner_req &&
                       ((owner_trans == TRANS_SEQ) || (owner_trans == TRANS_BUSY));

`ifdef REALTANK_BUSMTX_ARB_RR_EN
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_IN; i++) begin
      cand = 2'((int'(rr_ptr) + i) % NUM_IN);
      if (!pick_found && req_pad[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end
`else
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (req_pad[i]) begin
        pick_found = 1'b1;
        pick_idx   = 2'(i);
      end
    end
  end
`endif

  // A lock takes precedence over a burst; a locked owner that drops its request parks the port.
  always_comb begin
    state_n   = state;
    addr_n    = addr_in_port;
    no_port_n = no_port;
`ifdef REALTANK_BUSMTX_ARB_RR_EN
    grant_new = 1'b0;
`endif
    if ((state != NOPORT) && owner_lock) begin
      state_n   = LOCKED;
      no_port_n = ~owner_req;
    end else if ((state != NOPORT) && owner_burst) begin
      state_n   = OWNED;
      no_port_n = 1'b0;
    end else if (pick_found) begin
      state_n   = OWNED;
      addr_n    = pick_idx;
      no_port_n = 1'b0;
`ifdef REALTANK_BUSMTX_ARB_RR_EN
      grant_new = 1'b1;
`endif
    end else begin
      state_n   = NOPORT;
      no_port_n = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state        <= NOPORT;
      addr_in_port <= '0;
      no_port      <= 1'b1;
      data_in_port <= '0;
      data_valid   <= 1'b0;
`ifdef REALTANK_BUSMTX_ARB_RR_EN
      rr_ptr       <= LAST_IDX;
`endif
    end else if (HREADYM) begin
      state        <= state_n;
      addr_in_port <= addr_n;
      no_port      <= no_port_n;
      data_in_port <= addr_in_port;
      data_valid   <= ~no_port;
`ifdef REALTANK_BUSMTX_ARB_RR_EN
      if (grant_new) begin
        rr_ptr <= addr_n;
      end
`endif
    end
  end

  always_comb begin
    active_arb = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      active_arb[i] = !no_port && (addr_in_port == 2'(i));
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_realtank_soc_busmtx_out_arb.sv
// Directed bench for the MI0 output arbiter: a vector table plus hand-written burst and scheme sequences.
module tb_realtank_soc_busmtx_out_arb;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [3:0] req_in = '0;
  logic [7:0] trans_in = '0;
  logic [3:0] lock_in = '0;
  logic       HREADYM = 1'b1;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic [3:0] active_arb;
  logic [1:0] data_in_port;
  logic       data_valid;
  logic       locked;

  int testsRun = 0;
  int testsFailed = 0;

  realtank_soc_busmtx_out_arb #(.NUM_IN(4)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_in       (req_in),
    .trans_in     (trans_in),
    .lock_in      (lock_in),
    .HREADYM      (HREADYM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .active_arb   (active_arb),
    .data_in_port (data_in_port),
    .data_valid   (data_valid),
    .locked       (locked)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic       rst_n;
    logic       hready;
    logic [3:0] req;
    logic [7:0] trans;
    logic [3:0] lock;
    logic [1:0] e_addr;
    logic       e_np;
    logic [3:0] e_act;
    logic [1:0] e_data;
    logic       e_dv;
    logic       e_lk;
  } vec_t;

  localparam int NUM_VECS = 28;
  vec_t vecs [NUM_VECS];

  function automatic vec_t mk(input logic r, input logic h, input logic [3:0] q,
                              input logic [7:0] t, input logic [3:0] l,
                              input logic [1:0] ea, input logic enp, input logic [3:0] eac,
                              input logic [1:0] ed, input logic edv, input logic elk);
    vec_t v;
    v.rst_n = r;  v.hready = h; v.req = q; v.trans = t; v.lock = l;
    v.e_addr = ea; v.e_np = enp; v.e_act = eac; v.e_data = ed; v.e_dv = edv; v.e_lk = elk;
    return v;
  endfunction

  // Drive on the falling edge, then let one rising edge act on it.
  task automatic applyStimulus(input logic r, input logic h, input logic [3:0] q,
                               input logic [7:0] t, input logic [3:0] l);
    @(negedge HCLK);
    HRESETn  = r;
    HREADYM  = h;
    req_in   = q;
    trans_in = t;
    lock_in  = l;
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] ea, input logic enp,
                             input logic [3:0] eac, input logic [1:0] ed, input logic edv,
                             input logic elk);
    testsRun++;
    if (addr_in_port !== ea || no_port !== enp || active_arb !== eac ||
        data_in_port !== ed || data_valid !== edv || locked !== elk) begin
      testsFailed++;
      $display("[TB] FAIL %s: got addr=%0d np=%b act=%b data=%0d dv=%b lk=%b, want addr=%0d np=%b act=%b data=%0d dv=%b lk=%b",
               name, addr_in_port, no_port, active_arb, data_in_port, data_valid, locked,
               ea, enp, eac, ed, edv, elk);
    end
  endtask

  task automatic checkGrant(input string name, input logic [1:0] ea, input logic [3:0] eac);
    testsRun++;
    if (addr_in_port !== ea || active_arb !== eac || no_port !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s: got addr=%0d act=%b np=%b, want addr=%0d act=%b np=0",
               name, addr_in_port, active_arb, no_port, ea, eac);
    end
  endtask

  initial begin
    logic [1:0] rrExp [5];
    logic [1:0] g;

    // rst hr req trans lock | addr np act data dv lk
    vecs[0]  = mk(0, 1, 4'b0000, 8'h00, 4'b0000, 2'd0, 1, 4'b0000, 2'd0, 0, 0);
    vecs[1]  = mk(1, 1, 4'b0000, 8'h00, 4'b0000, 2'd0, 1, 4'b0000, 2'd0, 0, 0);
    vecs[2]  = mk(1, 1, 4'b0000, 8'h00, 4'b0000, 2'd0, 1, 4'b0000, 2'd0, 0, 0);
    vecs[3]  = mk(1, 1, 4'b0000, 8'h00, 4'b0000, 2'd0, 1, 4'b0000, 2'd0, 0, 0);
    vecs[4]  = mk(1, 1, 4'b0000, 8'h00, 4'b0000, 2'd0, 1, 4'b0000, 2'd0, 0, 0);
    vecs[5]  = mk(1, 1, 4'b0000, 8'h00, 4'b0000, 2'd0, 1, 4'b0000, 2'd0, 0, 0);
    vecs[6]  = mk(1, 1, 4'b0100, 8'b0010_0000, 4'b0000, 2'd2, 0, 4'b0100, 2'd0, 0, 0);
    vecs[7]  = mk(1, 1, 4'b0000, 8'h00, 4'b0000, 2'd2, 1, 4'b0000, 2'd2, 1, 0);
    vecs[8]  = mk(1, 1, 4'b0000, 8'h00, 4'b0000, 2'd2, 1, 4'b0000, 2'd2, 0, 0);
    // S1 INCR4 burst with S0 requesting
    vecs[9]  = mk(1, 1, 4'b0010, 8'b0000_1000, 4'b0000, 2'd1, 0, 4'b0010, 2'd2, 0, 0);
    vecs[10] = mk(1, 1, 4'b0011, 8'b0000_1110, 4'b0000, 2'd1, 0, 4'b0010, 2'd1, 1, 0);
    vecs[11] = mk(1, 1, 4'b0011, 8'b0000_1110, 4'b0000, 2'd1, 0, 4'b0010, 2'd1, 1, 0);
    vecs[12] = mk(1, 1, 4'b0011, 8'b0000_1110, 4'b0000, 2'd1, 0, 4'b0010, 2'd1, 1, 0);
    vecs[13] = mk(1, 1, 4'b0001, 8'b0000_0010, 4'b0000, 2'd0, 0, 4'b0001, 2'd1, 1, 0);
    // S3 locked sequence with an IDLE gap
    vecs[14] = mk(1, 1, 4'b1000, 8'b1000_0000, 4'b1000, 2'd3, 0, 4'b1000, 2'd0, 1, 0);
    vecs[15] = mk(1, 1, 4'b1001, 8'b1000_0010, 4'b1000, 2'd3, 0, 4'b1000, 2'd3, 1, 1);
    vecs[16] = mk(1, 1, 4'b0001, 8'b0000_0010, 4'b1000, 2'd3, 1, 4'b0000, 2'd3, 1, 1);
    vecs[17] = mk(1, 1, 4'b1001, 8'b1000_0010, 4'b1000, 2'd3, 0, 4'b1000, 2'd3, 0, 1);
    vecs[18] = mk(1, 1, 4'b0001, 8'b0000_0010, 4'b0000, 2'd0, 0, 4'b0001, 2'd3, 1, 0);
    // HREADYM stall while the request moves from S0 to S1
    vecs[19] = mk(1, 1, 4'b0001, 8'b0000_0010, 4'b0000, 2'd0, 0, 4'b0001, 2'd0, 1, 0);
    vecs[20] = mk(1, 0, 4'b0010, 8'b0000_1000, 4'b0000, 2'd0, 0, 4'b0001, 2'd0, 1, 0);
    vecs[21] = mk(1, 0, 4'b0010, 8'b0000_1000, 4'b0000, 2'd0, 0, 4'b0001, 2'd0, 1, 0);
    vecs[22] = mk(1, 0, 4'b0010, 8'b0000_1000, 4'b0000, 2'd0, 0, 4'b0001, 2'd0, 1, 0);
    vecs[23] = mk(1, 1, 4'b0010, 8'b0000_1000, 4'b0000, 2'd1, 0, 4'b0010, 2'd0, 1, 0);
    // Reset in the middle of an S2 burst, with HREADYM low
    vecs[24] = mk(1, 1, 4'b0100, 8'b0010_0000, 4'b0000, 2'd2, 0, 4'b0100, 2'd1, 1, 0);
    vecs[25] = mk(1, 1, 4'b0100, 8'b0011_0000, 4'b0000, 2'd2, 0, 4'b0100, 2'd2, 1, 0);
    vecs[26] = mk(0, 0, 4'b0100, 8'b0011_0000, 4'b0000, 2'd0, 1, 4'b0000, 2'd0, 0, 0);
    vecs[27] = mk(1, 1, 4'b0101, 8'b0010_0010, 4'b0000, 2'd0, 0, 4'b0001, 2'd0, 0, 0);

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].hready, vecs[i].req, vecs[i].trans, vecs[i].lock);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_np, vecs[i].e_act,
                  vecs[i].e_data, vecs[i].e_dv, vecs[i].e_lk);
    end

    // BUSY and SEQ both hold S1; its next NONSEQ lets S0 back in under either scheme.
    applyStimulus(1, 1, 4'b0010, 8'b0000_1000, 4'b0000);
    checkGrant("busy_grant", 2'd1, 4'b0010);
    applyStimulus(1, 1, 4'b0011, 8'b0000_0110, 4'b0000);
    checkGrant("busy_hold", 2'd1, 4'b0010);
    applyStimulus(1, 1, 4'b0011, 8'b0000_1110, 4'b0000);
    checkGrant("seq_hold", 2'd1, 4'b0010);
    applyStimulus(1, 1, 4'b0011, 8'b0000_1010, 4'b0000);
    checkGrant("burst_end", 2'd0, 4'b0001);

    // All four requesting NONSEQ from reset: rotation or a fixed grant to S0.
    applyStimulus(0, 1, 4'b0000, 8'h00, 4'b0000);
    checkOutput("sched_reset", 2'd0, 1, 4'b0000, 2'd0, 0, 0);
`ifdef REALTANK_BUSMTX_ARB_RR_EN
    rrExp[0] = 2'd0; rrExp[1] = 2'd1; rrExp[2] = 2'd2; rrExp[3] = 2'd3; rrExp[4] = 2'd0;
`else
    rrExp[0] = 2'd0; rrExp[1] = 2'd0; rrExp[2] = 2'd0; rrExp[3] = 2'd0; rrExp[4] = 2'd0;
`endif
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 4'b1111, 8'b1010_1010, 4'b0000);
      g = rrExp[i];
      checkGrant($sformatf("sched%0d", i), g, 4'b0001 << g);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/realtank_soc_busmtx_out_arb.md
# realtank_soc_busmtx_out_arb

Output-stage arbiter for the RealTank SoC bus matrix. It shares one output port (MI0) between up to four input stages (S0..S3). It decides which input stage owns the output port's address phase, keeps that owner for the length of any continuing burst or locked sequence, and tracks the data-phase owner so that response and read data are routed back. It sits between the input-stage holding registers and the output-stage address/data multiplexers.

## Interface
- NUM_IN, 4, number of input stages; legal values 2..4; unused request bits are tied low.
- HCLK  input  1  AHB system clock.
- HRESETn  input  1  synchronous active-low reset.
- req_in  input  NUM_IN  per-input request: the input stage has a pending non-IDLE transfer decoded to this port.
- trans_in  input  2*NUM_IN  HTRANS of each input stage (2 bits per input, input n in bits [2n+1:2n]).
- lock_in  input  NUM_IN  HMASTLOCK of each input stage.
- HREADYM  input  1  HREADY of the output port; completes the current data phase.
- addr_in_port  output  2  input stage that owns the address phase.
- no_port  output  1  high when no input stage owns the port; the output stage then drives HTRANS=IDLE.
- active_arb  output  NUM_IN  one-hot address-phase owner; all zeros when no_port=1.
- data_in_port  output  2  input stage that owns the current data phase.
- data_valid  output  1  the data phase belongs to a real owner, i.e. it is not the data phase of a no_port cycle.
- locked  output  1  the arbiter is in the LOCKED state.

## Operation
- The arbiter has three states:
  - NOPORT: no owner.
  - OWNED: an owner exists and can be replaced.
  - LOCKED: an owner exists and is held for a locked sequence.
- All grant decisions are taken only in cycles where HREADYM=1. When HREADYM=0, every register holds its value.
- Hold conditions, checked in cycles where HREADYM=1 and the arbiter is not in NOPORT. The owner is kept when either of these holds:
  - trans_in[owner] is SEQ (2'b11) or BUSY (2'b01) and req_in[owner]=1. This is a burst continuation.
  - lock_in[owner]=1. The next state is LOCKED.
- Re-arbitration: when no hold condition applies, a new owner is selected from req_in using the selected scheme (see Configuration). The next state is OWNED.
- If req_in is all zeros, the next state is NOPORT. addr_in_port keeps its last value; no_port=1.
- LOCKED exit: when lock_in[owner]=0 and there is no burst continuation, re-arbitration happens in the same HREADYM=1 cycle.
- If the owner drops req_in while LOCKED, the state stays LOCKED with no_port=1 and the other requesters are masked. LOCKED is left only when lock_in[owner] falls.
- Data-phase tracking: in each cycle where HREADYM=1, data_in_port <= addr_in_port and data_valid <= ~no_port.
- Indices at or above NUM_IN are never granted.

## Timing
- The grant is registered. A request first seen in a cycle where HREADYM=1 appears on addr_in_port/active_arb in the next cycle. Request-to-grant latency is 1 cycle when the port is free.
- data_in_port follows addr_in_port by one completed transfer, i.e. one cycle where HREADYM=1.
- Reset values: state=NOPORT, addr_in_port=0, no_port=1, active_arb=0, data_in_port=0, data_valid=0, locked=0, round-robin pointer = NUM_IN-1, so that input 0 is favoured first.
- Reset asserted mid-burst or mid-lock: all registers take their reset values at the next HCLK edge, regardless of HREADYM.
- A new request arriving in the same cycle that the owner completes its burst competes normally. The owner is eligible again only per the selected scheme.
- When HREADYM=0 for several cycles, active_arb stays stable; it has no glitches.

## Configuration
- REALTANK_BUSMTX_ARB_RR_EN defined: round-robin scheme. The search starts at the last granted index + 1, modulo NUM_IN. The pointer updates only when a new grant is issued.
- REALTANK_BUSMTX_ARB_RR_EN undefined: fixed-priority scheme. Index 0 has the highest priority and NUM_IN-1 the lowest. The round-robin pointer is not implemented.

## Test plan
- Reset release, req_in=4'b0000 for 5 cycles -> no_port=1, active_arb=0, data_valid=0 throughout. Then req_in=4'b0100 with HREADYM=1 -> next cycle addr_in_port=2, active_arb=4'b0100. One cycle later, data_in_port=2 and data_valid=1.
- RR_EN defined, req_in=4'b1111, all trans NONSEQ, HREADYM=1 -> grant sequence 0,1,2,3,0. RR_EN undefined, same stimulus -> grant stays 0.
- S1 performs an INCR4 burst (NONSEQ,SEQ,SEQ,SEQ) while S0 requests continuously -> S1 is held for 4 beats; S0 is granted in the cycle after the last SEQ is accepted.
- S3 has lock_in=1 across two transfers with an IDLE gap, while S0 requests -> locked=1, S0 is not granted and no_port=1 during the gap. S0 is granted the cycle after lock_in[3] falls.
- HREADYM=0 for 3 cycles while req_in changes from 4'b0001 to 4'b0010 -> addr_in_port, data_in_port and state are unchanged until HREADYM returns to 1.
- HRESETn=0 asserted during an S2 burst -> the next edge gives state NOPORT, no_port=1, data_valid=0. After release, req_in=4'b0101 -> S0 is granted first.
